// File: rtl/uart_tx_frame_ctrl_pkg.sv
// Shared encodings for the UART transmit frame controller: FSM states,
// fixed line levels and the parity-type selector.
package uart_tx_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// Byte handshake, shift-stage link and serial line of the UART transmit
// frame controller; master is the upstream/shift-stage side, slave the controller.
interface uart_tx_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] P_Data;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  Ser_Data;
  logic                  Ser_Done;
  logic                  Ser_En;
  logic                  busy;
  logic                  TX_OUT;

  modport master (
    output P_Data, Data_Valid, PAR_EN, PAR_TYP, Ser_Data, Ser_Done,
    input  Ser_En, busy, TX_OUT
  );

  modport slave (
    input  P_Data, Data_Valid, PAR_EN, PAR_TYP, Ser_Data, Ser_Done,
    output Ser_En, busy, TX_OUT
  );

endinterface

// File: rtl/uart_tx_frame_ctrl_parity.sv
// Parity bit for the latched byte: XOR-reduce, inverted for odd parity.
module uart_parity_calc
  import uart_tx_frame_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity_bit
);

  // Even parity makes the total count of ones even, so it equals the plain reduction.
  assign parity_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: accepts a byte in IDLE, sequences
// start/data/parity/stop on TX_OUT and steers the external shift stage.
module uart_tx_frame_ctrl
  import uart_tx_frame_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_frame_ctrl_if.slave  tx_if
);

  localparam int WD_W = $clog2(DATA_WIDTH + 2) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(DATA_WIDTH + 1);

  state_e                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic [WD_W-1:0]         wdog_q, wdog_d;
  logic                    parity_bit;
  logic                    tx_out;

  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data       (data_q),
    .par_typ    (par_typ_q),
    .parity_bit (parity_bit)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    wdog_d    = wdog_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_if.Data_Valid) begin
          state_d   = ST_START;
          busy_d    = 1'b1;
          data_d    = tx_if.P_Data;
          par_en_d  = tx_if.PAR_EN;
          par_typ_d = tx_if.PAR_TYP;
        end
      end
      ST_START: begin
        state_d = ST_DATA;
        wdog_d  = '0;
      end
      ST_DATA: begin
        wdog_d = wdog_q + 1'b1;
        // A missing done strobe must not hang the line: give up after two spare cycles.
        if (tx_if.Ser_Done) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end else if (wdog_q == WD_LAST) begin
          state_d = ST_STOP;
        end
      end
      ST_PARITY: begin
        state_d = ST_STOP;
      end
      ST_STOP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      wdog_q    <= wdog_d;
    end
  end

  // The shift stage must stop advancing on the cycle its last bit is on the line.
  assign tx_if.Ser_En = (state_q == ST_START) ||
                        ((state_q == ST_DATA) && !tx_if.Ser_Done);

  always_comb begin
    tx_out = IDLE_LEVEL;
    case (state_q)
      ST_START:  tx_out = START_BIT;
      ST_DATA:   tx_out = tx_if.Ser_Data;
      ST_PARITY: tx_out = parity_bit;
      ST_STOP:   tx_out = STOP_BIT;
      default:   tx_out = IDLE_LEVEL;
    endcase
  end

  assign tx_if.TX_OUT = tx_out;
  assign tx_if.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed bench for uart_tx_frame_ctrl with a behavioural 8-bit shift stage
// that loads on acceptance and raises a one-cycle done with its last bit.
module tb_uart_tx_frame_ctrl;

  logic clk;
  logic rst;
  logic withhold;
  int   checks;
  int   errors;

  uart_tx_frame_ctrl_if #(.DATA_WIDTH(8)) ifc ();

  uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .tx_if (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift stage model
  logic [7:0] sh_q;
  logic       ser_q;
  logic       done_q;
  logic [4:0] cnt_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= 8'h00;
      ser_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= 5'd0;
    end else begin
      done_q <= 1'b0;
      if (ifc.Data_Valid && !ifc.busy) begin
        sh_q  <= ifc.P_Data;
        cnt_q <= 5'd0;
      end else if (ifc.Ser_En) begin
        ser_q  <= sh_q[0];
        sh_q   <= sh_q >> 1;
        cnt_q  <= cnt_q + 5'd1;
        done_q <= (cnt_q == 5'd7) && !withhold;
      end
    end
  end

  assign ifc.Ser_Data = ser_q;
  assign ifc.Ser_Done = done_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt);
    @(negedge clk);
    ifc.P_Data     = d;
    ifc.PAR_EN     = pe;
    ifc.PAR_TYP    = pt;
    ifc.Data_Valid = 1'b1;
    @(negedge clk);
    ifc.Data_Valid = 1'b0;
  endtask

  // Called at the negedge of the START cycle; returns at the negedge of the following IDLE cycle.
  task automatic check_frame(input string tag, input logic [0:11] exp, input int len,
                             input int exp_sen);
    int sen;
    sen = 0;
    for (int i = 0; i < len; i++) begin
      chk($sformatf("%s tx[%0d]", tag, i), 32'(ifc.TX_OUT), 32'(exp[i]));
      chk($sformatf("%s busy[%0d]", tag, i), 32'(ifc.busy), 32'd1);
      if (ifc.Ser_En) sen++;
      @(negedge clk);
    end
    chk($sformatf("%s ser_en_cycles", tag), 32'(sen), 32'(exp_sen));
    chk($sformatf("%s idle_tx", tag), 32'(ifc.TX_OUT), 32'd1);
    chk($sformatf("%s idle_busy", tag), 32'(ifc.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    checks         = 0;
    errors         = 0;
    withhold       = 1'b0;
    rst            = 1'b1;
    ifc.P_Data     = 8'h00;
    ifc.Data_Valid = 1'b0;
    ifc.PAR_EN     = 1'b0;
    ifc.PAR_TYP    = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset tx", 32'(ifc.TX_OUT), 32'd1);
    chk("reset busy", 32'(ifc.busy), 32'd0);
    chk("reset ser_en", 32'(ifc.Ser_En), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle tx", 32'(ifc.TX_OUT), 32'd1);

    // 0xA5 even parity
    send(8'hA5, 1'b1, 1'b0);
    check_frame("a5_even", 12'b0101_0010_1010, 11, 8);

    // 0x01 odd parity
    send(8'h01, 1'b1, 1'b1);
    check_frame("01_odd", 12'b0100_0000_0010, 11, 8);

    // 0x3C without parity
    send(8'h3C, 1'b0, 1'b0);
    check_frame("3c_nopar", 12'b0001_1110_0100, 10, 8);

    // Back-to-back with Data_Valid held high
    @(negedge clk);
    ifc.P_Data     = 8'h55;
    ifc.PAR_EN     = 1'b1;
    ifc.PAR_TYP    = 1'b0;
    ifc.Data_Valid = 1'b1;
    @(negedge clk);
    ifc.P_Data = 8'hAA;
    check_frame("b2b_55", 12'b0101_0101_0010, 11, 8);
    @(negedge clk);
    ifc.Data_Valid = 1'b0;
    check_frame("b2b_aa", 12'b0010_1010_1010, 11, 8);

    // Asynchronous reset in the 4th DATA cycle
    send(8'h00, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("rst_mid pre tx", 32'(ifc.TX_OUT), 32'd0);
    chk("rst_mid pre busy", 32'(ifc.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid tx", 32'(ifc.TX_OUT), 32'd1);
    chk("rst_mid busy", 32'(ifc.busy), 32'd0);
    chk("rst_mid ser_en", 32'(ifc.Ser_En), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h3C, 1'b0, 1'b0);
    check_frame("post_rst_3c", 12'b0001_1110_0100, 10, 8);

    // Config and data changed after acceptance
    send(8'hA5, 1'b1, 1'b0);
    ifc.PAR_TYP = 1'b1;
    ifc.PAR_EN  = 1'b0;
    ifc.P_Data  = 8'hFF;
    check_frame("latched_cfg", 12'b0101_0010_1010, 11, 8);

    // Ser_Done withheld: watchdog ends DATA after 10 cycles, no parity bit
    withhold = 1'b1;
    send(8'h81, 1'b1, 1'b0);
    check_frame("watchdog", 12'b0100_0000_1001, 12, 11);
    withhold = 1'b0;
    @(negedge clk);
    chk("after_wd idle tx", 32'(ifc.TX_OUT), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
